// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the internal bus arbiter:
// requester ids, FSM encoding and BIU source select.
package bus_arbiter_pkg;

  localparam int REQ_FCU = 0;
  localparam int REQ_EU  = 1;
  localparam int REQ_CTL = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_FCU = 2'd0,
    SEL_EU  = 2'd1,
    SEL_CTL = 2'd2
  } bus_sel_e;

  // Source select driven while the bus has no owner
  localparam logic [1:0] SEL_IDLE = 2'd0;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner picker: round-robin after last_i,
// or strict priority (lowest index) when FIXED_PRI=1.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic            valid_o,
  output logic [1:0]      idx_o
);

  int j;

  // Scan from the lowest-priority candidate up so the
  // highest-priority set request is the final write.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    j       = 0;
    for (int off = NREQ; off >= 1; off--) begin
      if (FIXED_PRI)
        j = off - 1;
      else
        j = (int'(last_i) + off) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == j && req_i[i])
          idx_o = 2'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Internal 16-bit bus arbiter: one owner at a time,
// turnaround cycle between tenures, watchdog release.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TIMEOUT   = 15,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            cs_bus,
  output logic [1:0]      bus_sel,
  output logic            timeout_err,
  output logic [7:0]      err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    err_q, err_d;

  logic          pick_valid;
  logic [1:0]    pick_idx;

  rr_pick #(
    .NREQ      (NREQ),
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= 2'(NREQ - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = CW'(1);
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // done beats abandon, which beats the watchdog
        if (done[owner_q]) begin
          state_d = ST_REL;
        end else if (!req[owner_q]) begin
          state_d = ST_REL;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ST_REL;
          tmo_d   = 1'b1;
          err_d   = sat_inc8(err_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REL: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      gnt[i] = (state_q == ST_OWN) && (owner_q == 2'(i));
  end

  assign busy        = (state_q == ST_OWN);
  assign cs_bus      = busy;
  assign owner       = owner_q;
  assign bus_sel     = busy ? owner_q : SEL_IDLE;
  assign timeout_err = tmo_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant order, gaps,
// watchdog, done precedence and mid-tenure reset.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req, done, gnt;
  logic [1:0] owner, bus_sel;
  logic       busy, cs_bus, timeout_err;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .cs_bus      (cs_bus),
    .bus_sel     (bus_sel),
    .timeout_err (timeout_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  logic [2:0] order [4];

  initial begin
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    order[3] = 3'b001;
    reset = 1'b0;
    req   = '0;
    done  = '0;

    // reset state
    tick();
    tick();
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_cs", 16'(cs_bus), 16'h0);
    chk("rst_sel", 16'(bus_sel), 16'h0);
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_tmo", 16'(timeout_err), 16'h0);
    chk("rst_err", 16'(err_cnt), 16'h0);

    // single request, done on 4th grant cycle
    reset = 1'b1;
    req   = 3'b001;
    tick();
    chk("t1_gnt", 16'(gnt), 16'h1);
    chk("t1_busy", 16'(busy), 16'h1);
    chk("t1_cs", 16'(cs_bus), 16'h1);
    chk("t1_sel", 16'(bus_sel), 16'h0);
    tick();
    tick();
    tick();
    chk("t1_c4_gnt", 16'(gnt), 16'h1);
    done = 3'b001;
    tick();
    chk("t1_rel_gnt", 16'(gnt), 16'h0);
    chk("t1_rel_busy", 16'(busy), 16'h0);
    chk("t1_rel_tmo", 16'(timeout_err), 16'h0);
    chk("t1_rel_err", 16'(err_cnt), 16'h0);
    done = '0;
    req  = '0;
    tick();

    // round-robin 0,1,2,0 with 2-cycle gaps
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req   = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_gnt", k), 16'(gnt),
          16'(order[k]));
      tick();
      chk($sformatf("rr%0d_c2", k), 16'(gnt),
          16'(order[k]));
      done = order[k];
      tick();
      chk($sformatf("rr%0d_gap1", k), 16'(gnt), 16'h0);
      done = '0;
      if (k == 3) req = '0;
      tick();
      chk($sformatf("rr%0d_gap2", k), 16'(gnt), 16'h0);
      tick();
    end
    chk("rr_idle", 16'(gnt), 16'h0);

    // watchdog on requester 1
    req = 3'b010;
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("wd_c%0d", i), 16'(gnt), 16'h2);
      tick();
    end
    chk("wd_rel_gnt", 16'(gnt), 16'h0);
    chk("wd_rel_tmo", 16'(timeout_err), 16'h1);
    chk("wd_rel_err", 16'(err_cnt), 16'h1);
    tick();
    chk("wd_idle_tmo", 16'(timeout_err), 16'h0);
    tick();
    chk("wd_regrant", 16'(gnt), 16'h2);
    repeat (15) tick();
    for (int n = 0; n < 299; n++) begin
      tick();
      tick();
      repeat (15) tick();
    end
    chk("wd_sat_tmo", 16'(timeout_err), 16'h1);
    chk("wd_sat_err", 16'(err_cnt), 16'hFF);
    req = '0;
    tick();
    chk("wd_sat_hold", 16'(err_cnt), 16'hFF);
    chk("wd_sat_tmo0", 16'(timeout_err), 16'h0);

    // owner 2 ignores foreign done, releases on abandon
    req = 3'b100;
    tick();
    chk("ab_gnt", 16'(gnt), 16'h4);
    chk("ab_sel", 16'(bus_sel), 16'h2);
    done = 3'b011;
    tick();
    chk("ab_fdone1", 16'(gnt), 16'h4);
    tick();
    chk("ab_fdone2", 16'(gnt), 16'h4);
    done = '0;
    req  = '0;
    tick();
    chk("ab_rel_gnt", 16'(gnt), 16'h0);
    chk("ab_rel_tmo", 16'(timeout_err), 16'h0);
    chk("ab_rel_owner", 16'(owner), 16'h2);
    chk("ab_rel_sel", 16'(bus_sel), 16'h0);
    tick();

    // done coincident with watchdog expiry
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req   = 3'b001;
    tick();
    repeat (14) tick();
    chk("dt_c15", 16'(gnt), 16'h1);
    done = 3'b001;
    tick();
    chk("dt_rel_gnt", 16'(gnt), 16'h0);
    chk("dt_rel_tmo", 16'(timeout_err), 16'h0);
    chk("dt_rel_err", 16'(err_cnt), 16'h0);
    done = '0;

    // reset mid-tenure
    req = 3'b110;
    tick();
    tick();
    chk("mr_gnt", 16'(gnt), 16'h2);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_rst_gnt", 16'(gnt), 16'h0);
    chk("mr_rst_busy", 16'(busy), 16'h0);
    reset = 1'b1;
    tick();
    chk("mr_first", 16'(gnt), 16'h2);
    chk("mr_owner", 16'(owner), 16'h1);
    req = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates ownership of the shared 16-bit internal bus among three requesters: 0 = FCU (instruction fetch), 1 = EU (operand/result transfer), 2 = decoder/BIU control transfer.
- Round-robin grant, one owner at a time, with a turnaround cycle between owners.
- Each tenure is bounded by a watchdog. Outputs drive the BIU chip-select and the bus-source select, replacing the ad-hoc cs_biu/sel_biu sharing in the control unit.

Parameters:
- NREQ, 3, number of requesters (fixed 3 for this design; logic written generic 2..4).
- TIMEOUT, 15, maximum cycles a grant may be held before forced release.
- FIXED_PRI, 0, 1 = strict priority (index 0 highest) instead of round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester bus request, level; held until done or abandoned.
- done  input  NREQ  per-requester one-cycle completion pulse; valid only from the current owner.
- gnt  output  NREQ  one-hot grant; all-zero when no owner.
- owner  output  2  index of current/last owner.
- busy  output  1  high while any grant is active.
- cs_bus  output  1  BIU chip-select; equals busy.
- bus_sel  output  2  bus source select to BIU; equals owner while busy, 0 otherwise.
- timeout_err  output  1  one-cycle pulse when a tenure is force-released.
- err_cnt  output  8  saturating count of timeouts.

Behaviour:
- Reset (reset==0 at a clk edge):
  - gnt=0, busy=0, cs_bus=0, bus_sel=0, owner=0, timeout_err=0, err_cnt=0, tenure counter=0.
  - last_owner=NREQ-1, so requester 0 wins first. State=IDLE.
  - Reset mid-tenure drops gnt at that same edge; no done is required.
- FSM has three states:
  - IDLE:
    - gnt=0.
    - If any req bit is set, pick the winner and register gnt/owner. Next state=OWN.
    - Latency is exactly 1 cycle from req seen high to gnt high.
  - OWN:
    - gnt[owner]=1 and busy=1; the counter increments every cycle, starting at 1 in the first grant cycle.
    - If done[owner]=1, go to REL, no error.
    - Else if req[owner]=0 (abandon), go to REL, no error.
    - Else if counter==TIMEOUT, go to REL, pulse timeout_err in the REL cycle, and increment err_cnt (saturate at 255).
    - done and timeout in the same cycle: done wins.
  - REL:
    - gnt=0 and busy=0 for exactly one turnaround cycle; last_owner<=owner; counter<=0. Next state=IDLE.
    - owner keeps its value until the next grant.
- Winner selection:
  - Round-robin: the first set req scanning from last_owner+1 upward, modulo NREQ, wrapping around.
  - FIXED_PRI=1: the lowest set index.
  - Requests arriving during OWN/REL are only evaluated in IDLE.
- Throughput: two back-to-back requesters see gnt separated by a 2-cycle gap (REL + IDLE arbitration). Minimum tenure is 1 cycle.
- done from a non-owner is ignored. A req bit that drops while not granted is simply not considered.
- gnt is always one-hot or zero; never more than one bit is set.
- The counter width is enough to hold TIMEOUT.

Decomposition:
- Shared package holds:
  - requester index constants: REQ_FCU=0, REQ_EU=1, REQ_CTL=2;
  - the state encoding IDLE/OWN/REL;
  - the bus_sel encoding shared with biu.
- One sub-module, rr_pick: combinational round-robin/priority picker taking req, last_owner and FIXED_PRI, returning a valid flag and an index. It is reusable for the EU operation scheduler.

Test Plan:
- Reset then req=3'b001 → gnt=3'b001 one cycle later, busy=1, bus_sel=0. Pulse done[0] on the 4th grant cycle → gnt=0 next cycle, err_cnt=0.
- req=3'b111 held, each owner pulses done after 2 cycles → grant order 0,1,2,0, with a 2-cycle gnt-low gap between tenures.
- req[1] held, no done, TIMEOUT=15 → gnt[1] high exactly 15 cycles, timeout_err pulses once, err_cnt=1. Repeat 256+ times → err_cnt stays 255.
- Owner 2 granted, done[0] and done[1] pulsed → no release. Drop req[2] without done → release, timeout_err=0.
- done[owner] in the same cycle the counter reaches TIMEOUT → release with timeout_err=0, err_cnt unchanged.
- reset=0 asserted mid-tenure with req=3'b110 → gnt=0 at that edge. After release, the first grant goes to requester 1 (scan from 0).
